// File: rtl/vga_sync_decoder_if.sv
// Sync-stream bundle between a sync source / pixel consumer and the decoder.
// Latency: none; this bundle is wiring only.
// Backpressure: none; hsync/vsync arrive every pixel clock and status is always valid.
interface vga_sync_decoder_if;
    logic       hsync_in;
    logic       vsync_in;
    logic [9:0] column;
    logic [9:0] row;
    logic       display_enable;
    logic       locked;
    logic       frame_start;
    logic       h_err;
    logic       v_err;
    logic [7:0] err_count;

    // Source/consumer side: drives the syncs, reads recovered position and status.
    modport master (
        output hsync_in,
        output vsync_in,
        input  column,
        input  row,
        input  display_enable,
        input  locked,
        input  frame_start,
        input  h_err,
        input  v_err,
        input  err_count
    );

    // Decoder side.
    modport slave (
        input  hsync_in,
        input  vsync_in,
        output column,
        output row,
        output display_enable,
        output locked,
        output frame_start,
        output h_err,
        output v_err,
        output err_count
    );
endinterface

// File: rtl/vga_sync_decoder.sv
// Recovers raster row/column from active-low hsync/vsync and checks every sync edge against the timing.
// Latency: a sync fall sampled on one edge shows up in row/column/status the following cycle.
// Backpressure: none; the decoder tracks the sync stream every pixel clock and never stalls it.
module vga_sync_decoder #(
    parameter int H_VISIBLE_AREA = 640,
    parameter int H_FRONT_PORCH  = 16,
    parameter int H_SYNC_PULSE   = 96,
    parameter int H_WHOLE_LINE   = 800,
    parameter int V_VISIBLE_AREA = 480,
    parameter int V_FRONT_PORCH  = 10,
    parameter int V_SYNC_PULSE   = 2,
    parameter int V_WHOLE_FRAME  = 525,
    parameter int LOCK_FRAMES    = 2
) (
    input  logic              pixel_clk,
    input  logic              rst_n,
    vga_sync_decoder_if.slave sync_if
);

    localparam logic [1:0] ST_SEARCH  = 2'd0;
    localparam logic [1:0] ST_MEASURE = 2'd1;
    localparam logic [1:0] ST_LOCKED  = 2'd2;

    localparam logic [9:0] H_VIS        = 10'(H_VISIBLE_AREA);
    localparam logic [9:0] V_VIS        = 10'(V_VISIBLE_AREA);
    localparam logic [9:0] H_LAST       = 10'(H_WHOLE_LINE - 1);
    localparam logic [9:0] V_LAST       = 10'(V_WHOLE_FRAME - 1);
    localparam logic [9:0] H_SYNC_START = 10'(H_VISIBLE_AREA + H_FRONT_PORCH);
    localparam logic [9:0] H_SYNC_END   = 10'(H_VISIBLE_AREA + H_FRONT_PORCH + H_SYNC_PULSE);
    localparam logic [9:0] V_SYNC_START = 10'(V_VISIBLE_AREA + V_FRONT_PORCH);
    localparam logic [9:0] V_SYNC_END   = 10'(V_VISIBLE_AREA + V_FRONT_PORCH + V_SYNC_PULSE);
    // The hsync fall is seen one edge after the source sat at the sync start column,
    // so the source has already moved one column further when our load lands.
    localparam logic [9:0] H_LOAD       = 10'(H_VISIBLE_AREA + H_FRONT_PORCH + 1);
    localparam logic [3:0] LOCK_TARGET  = 4'(LOCK_FRAMES);

    logic [9:0] col_q, col_d;
    logic [9:0] row_q, row_d;
    logic [1:0] state_q, state_d;
    logic       hs_prev_q, vs_prev_q;
    logic       h_seen_q, h_seen_d;
    logic [3:0] frame_cnt_q, frame_cnt_d;
    logic       h_err_q, v_err_q;
    logic [7:0] err_cnt_q, err_cnt_d;

    logic       hs_fall, vs_fall;
    logic       exp_h, exp_v;
    logic       checking, h_mis, v_mis;
    logic       col_wrap, frame_end;
    logic [9:0] col_free, row_free;
    logic [3:0] frame_inc;

    // Sync falls, and the sync levels the current position says we should be seeing.
    always_comb begin
        hs_fall  = hs_prev_q & ~sync_if.hsync_in;
        vs_fall  = vs_prev_q & ~sync_if.vsync_in;
        exp_h    = ~((col_q >= H_SYNC_START) && (col_q < H_SYNC_END));
        exp_v    = ~((row_q >= V_SYNC_START) && (row_q < V_SYNC_END));
        checking = (state_q == ST_MEASURE) || (state_q == ST_LOCKED);
        h_mis    = checking && (sync_if.hsync_in != exp_h);
        v_mis    = checking && (sync_if.vsync_in != exp_v);
    end

    // Free-running raster advance, used whenever no sync load overrides it.
    always_comb begin
        col_wrap  = (col_q == H_LAST);
        frame_end = col_wrap && (row_q == V_LAST);
        col_free  = col_wrap ? 10'd0 : col_q + 10'd1;
        row_free  = row_q;
        if (col_wrap) begin
            row_free = (row_q == V_LAST) ? 10'd0 : row_q + 10'd1;
        end
    end

    // Acquisition state machine: load position in SEARCH, verify it in MEASURE/LOCKED.
    always_comb begin
        col_d       = col_free;
        row_d       = row_free;
        state_d     = state_q;
        h_seen_d    = h_seen_q;
        frame_cnt_d = frame_cnt_q;
        frame_inc   = frame_cnt_q + 4'd1;
        case (state_q)
            ST_SEARCH: begin
                if (hs_fall) begin
                    // Column load also freezes the row, even on a would-be wrap edge.
                    col_d    = H_LOAD;
                    row_d    = row_q;
                    h_seen_d = 1'b1;
                end
                // A vsync fall only means something once horizontal phase is known.
                if (vs_fall && h_seen_q) begin
                    row_d       = V_SYNC_START;
                    frame_cnt_d = 4'd0;
                    state_d     = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                if (h_mis || v_mis) begin
                    state_d  = ST_SEARCH;
                    h_seen_d = 1'b0;
                end else if (frame_end) begin
                    // The partial frame after entry counts as the first clean wrap.
                    frame_cnt_d = frame_inc;
                    if (frame_inc == LOCK_TARGET) begin
                        state_d = ST_LOCKED;
                    end
                end
            end
            ST_LOCKED: begin
                if (h_mis || v_mis) begin
                    state_d  = ST_SEARCH;
                    h_seen_d = 1'b0;
                end
            end
            default: begin
                state_d  = ST_SEARCH;
                h_seen_d = 1'b0;
            end
        endcase
    end

    // Saturating mismatch-event counter; an edge with both errors is one event.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if ((h_mis || v_mis) && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge pixel_clk) begin
        if (!rst_n) begin
            col_q       <= 10'd0;
            row_q       <= 10'd0;
            state_q     <= ST_SEARCH;
            hs_prev_q   <= 1'b1;
            vs_prev_q   <= 1'b1;
            h_seen_q    <= 1'b0;
            frame_cnt_q <= 4'd0;
            h_err_q     <= 1'b0;
            v_err_q     <= 1'b0;
            err_cnt_q   <= 8'd0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            state_q     <= state_d;
            hs_prev_q   <= sync_if.hsync_in;
            vs_prev_q   <= sync_if.vsync_in;
            h_seen_q    <= h_seen_d;
            frame_cnt_q <= frame_cnt_d;
            h_err_q     <= h_mis;
            v_err_q     <= v_mis;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign sync_if.column         = col_q;
    assign sync_if.row            = row_q;
    assign sync_if.locked         = (state_q == ST_LOCKED);
    assign sync_if.display_enable = (state_q == ST_LOCKED) && (col_q < H_VIS) && (row_q < V_VIS);
    assign sync_if.frame_start    = (state_q == ST_LOCKED) && (col_q == 10'd0) && (row_q == 10'd0);
    assign sync_if.h_err          = h_err_q;
    assign sync_if.v_err          = v_err_q;
    assign sync_if.err_count      = err_cnt_q;

endmodule
